baccarat_ctrl: RTL

BACCARAT_CTRL -- requirements
Module: baccarat_ctrl

---
 rtl/baccarat_pkg.sv | 39 +++
 rtl/scorehand.sv | 16 +
 rtl/baccarat_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat dealer controller.
package baccarat_pkg;

  typedef enum logic [3:0] {
    DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, CHECK,
    DEAL_P3, CHECK_D, DEAL_D3, RESULT
  } state_e;

  localparam logic [3:0] FACE_TH = 4'd10;
  localparam logic [4:0] MODULUS = 5'd10;

  // Tens, faces and the out-of-range codes 14/15 are all worth nothing.
  function automatic logic [3:0] card_val(input logic [3:0] c);
    return (c >= FACE_TH) ? 4'd0 : c;
  endfunction

  // Sum of three card values is at most 27, so two conditional subtracts suffice.
  function automatic logic [3:0] mod_total(input logic [4:0] s);
    logic [4:0] r;
    r = s;
    if (r >= MODULUS) r = r - MODULUS;
    if (r >= MODULUS) r = r - MODULUS;
    return 4'(r);
  endfunction

  function automatic logic banker_draws(input logic [3:0] dscore, input logic [3:0] p3);
    logic draw;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (p3 != 4'd8);
      4'd4:             draw = (p3 >= 4'd2) && (p3 <= 4'd7);
      4'd5:             draw = (p3 >= 4'd4) && (p3 <= 4'd7);
      4'd6:             draw = (p3 >= 4'd6) && (p3 <= 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

endpackage

// File: rtl/scorehand.sv
// Baccarat hand total (0..9) from up to three card ranks; 0 means not dealt.
module scorehand
  import baccarat_pkg::*;
(
  input  logic [3:0] card1,
  input  logic [3:0] card2,
  input  logic [3:0] card3,
  output logic [3:0] total
);

  logic [4:0] sum;

  assign sum   = {1'b0, card_val(card1)} + {1'b0, card_val(card2)} + {1'b0, card_val(card3)};
  assign total = mod_total(sum);

endmodule

// File: rtl/baccarat_ctrl.sv
// Baccarat dealing controller: sequences the six card slots, applies the
// third-card rules and lights the winner once the hand is complete.
module baccarat_ctrl
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       step,
  input  logic [3:0] new_card,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       done
);

  state_e state_q, state_d;
  logic [3:0] pcard1_q, pcard2_q, pcard3_q, dcard1_q, dcard2_q, dcard3_q;
  logic ld_p1, ld_p2, ld_p3, ld_d1, ld_d2, ld_d3;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) state_q <= DEAL_P1;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_p1 = 1'b0; ld_p2 = 1'b0; ld_p3 = 1'b0;
    ld_d1 = 1'b0; ld_d2 = 1'b0; ld_d3 = 1'b0;
    case (state_q)
      DEAL_P1: if (step) begin ld_p1 = 1'b1; state_d = DEAL_D1; end
      DEAL_D1: if (step) begin ld_d1 = 1'b1; state_d = DEAL_P2; end
      DEAL_P2: if (step) begin ld_p2 = 1'b1; state_d = DEAL_D2; end
      DEAL_D2: if (step) begin ld_d2 = 1'b1; state_d = CHECK;   end
      CHECK: begin
        if (pscore >= 4'd8 || dscore >= 4'd8) state_d = RESULT;
        else if (pscore <= 4'd5)              state_d = DEAL_P3;
        else if (dscore <= 4'd5)              state_d = DEAL_D3;
        else                                  state_d = RESULT;
      end
      DEAL_P3: if (step) begin ld_p3 = 1'b1; state_d = CHECK_D; end
      // Banker's decision depends on the value of the player's third card.
      CHECK_D: state_d = banker_draws(dscore, card_val(pcard3_q)) ? DEAL_D3 : RESULT;
      DEAL_D3: if (step) begin ld_d3 = 1'b1; state_d = RESULT; end
      RESULT:  state_d = RESULT;
      default: state_d = DEAL_P1;
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      pcard1_q <= 4'd0; pcard2_q <= 4'd0; pcard3_q <= 4'd0;
      dcard1_q <= 4'd0; dcard2_q <= 4'd0; dcard3_q <= 4'd0;
    end else begin
      if (ld_p1) pcard1_q <= new_card;
      if (ld_p2) pcard2_q <= new_card;
      if (ld_p3) pcard3_q <= new_card;
      if (ld_d1) dcard1_q <= new_card;
      if (ld_d2) dcard2_q <= new_card;
      if (ld_d3) dcard3_q <= new_card;
    end
  end

  scorehand u_pscore (.card1(pcard1_q), .card2(pcard2_q), .card3(pcard3_q), .total(pscore));
  scorehand u_dscore (.card1(dcard1_q), .card2(dcard2_q), .card3(dcard3_q), .total(dscore));

  assign pcard1 = pcard1_q;
  assign pcard2 = pcard2_q;
  assign pcard3 = pcard3_q;
  assign dcard1 = dcard1_q;
  assign dcard2 = dcard2_q;
  assign dcard3 = dcard3_q;

  // A tie lights both.
  assign done             = (state_q == RESULT);
  assign player_win_light = done && (pscore >= dscore);
  assign dealer_win_light = done && (dscore >= pscore);

endmodule
